// File: rtl/led_blink_scheduler.sv
// LED blink scheduler: runs ON/OFF blink commands on a prescaled tick.
// Optional macro LED_BLINK_INFINITE_EN makes cmd_rep==0 repeat until abort.
module led_blink_scheduler #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned LED_W    = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LED_W-1:0] cmd_mask,
    input  logic [15:0]      cmd_on,
    input  logic [15:0]      cmd_off,
    input  logic [7:0]       cmd_rep,
    input  logic             abort,
    output logic [LED_W-1:0] led,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PW = 16;
    localparam int unsigned RW = 8;
`ifdef LED_BLINK_INFINITE_EN
    localparam bit INF_EN = 1'b1;
`else
    localparam bit INF_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [RW-1:0]     rep_q, rep_d;
    logic [LED_W-1:0]  mask_q, mask_d;
    logic [PW-1:0]     on_q, on_d;
    logic [PW-1:0]     off_q, off_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic              tick;
    logic              accept;
    logic              rep_end;
    logic              rep_inf;

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            phase_q <= '0;
            rep_q   <= '0;
            mask_q  <= '0;
            on_q    <= '0;
            off_q   <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
            rep_q   <= rep_d;
            mask_q  <= mask_d;
            on_q    <= on_d;
            off_q   <= off_d;
            led_q   <= led_d;
        end
    end

    // Next-state, counters and registered LED drive
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rep_d   = rep_q;
        mask_d  = mask_q;
        on_d    = on_q;
        off_d   = off_q;
        rep_end = 1'b0;
        tick    = (presc_q == PW'(TICK_DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
        accept  = cmd_valid && cmd_ready;
        rep_inf = INF_EN && (rep_q == '0);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mask_d  = cmd_mask;
                    on_d    = cmd_on;
                    off_d   = cmd_off;
                    rep_d   = cmd_rep;
                    presc_d = '0;
                    phase_d = '0;
                    if (!INF_EN && (cmd_rep == '0)) begin
                        state_d = S_DONE;
                    end else if (cmd_on != '0) begin
                        state_d = S_ON;
                    end else if (cmd_off != '0) begin
                        state_d = S_OFF;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ON: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (tick) begin
                    if (phase_q + PW'(1) == on_q) begin
                        phase_d = '0;
                        if (off_q != '0) begin
                            state_d = S_OFF;
                        end else begin
                            rep_end = 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            S_OFF: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (tick) begin
                    if (phase_q + PW'(1) == off_q) begin
                        phase_d = '0;
                        rep_end = 1'b1;
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Repetition bookkeeping; an infinite command never counts down
        if (rep_end) begin
            if (rep_inf) begin
                state_d = (on_q != '0) ? S_ON : S_OFF;
            end else begin
                rep_d = rep_q - RW'(1);
                if (rep_q == RW'(1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = (on_q != '0) ? S_ON : S_OFF;
                end
            end
        end

        led_d = (state_d == S_ON) ? mask_d : '0;
    end

    // Outputs decoded from registered state
    always_comb begin
        cmd_ready = (state_q == S_IDLE) && !abort && !sys_rst;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        led       = led_q;
    end

endmodule

// File: doc/led_blink_scheduler.md
LED_BLINK_SCHEDULER -- requirements
Module: led_blink_scheduler

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 50000, giving sys_clk cycles per blink tick (1 ms at 50 MHz); legal range 2..65535.
REQ-002 SHALL provide parameter LED_W, default 4, giving the LED output width.
REQ-003 SHALL provide port sys_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL provide port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL provide port cmd_valid, input, 1 bit: command offered.
REQ-006 SHALL provide port cmd_ready, output, 1 bit: command can be accepted this cycle.
REQ-007 SHALL provide port cmd_mask, input, LED_W bits: LEDs driven during ON phases.
REQ-008 SHALL provide port cmd_on, input, 16 bits: ON phase length in ticks.
REQ-009 SHALL provide port cmd_off, input, 16 bits: OFF phase length in ticks.
REQ-010 SHALL provide port cmd_rep, input, 8 bits: number of ON/OFF repetitions.
REQ-011 SHALL provide port abort, input, 1 bit: terminate the running command.
REQ-012 SHALL provide port led, output, LED_W bits: registered LED drive.
REQ-013 SHALL provide port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 SHALL provide port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 SHALL implement a prescaler counting 0..TICK_DIV-1 that asserts an internal tick at count TICK_DIV-1, wraps to 0, and is cleared on command accept, so the first tick falls TICK_DIV cycles after accept.
REQ-016 SHALL implement states IDLE, ON, OFF and DONE.
REQ-017 SHALL drive cmd_ready = (state==IDLE) && !abort.
REQ-018 SHALL accept a command on cmd_valid && cmd_ready and latch mask, on, off and rep.
REQ-019 SHALL ignore cmd_valid while busy; no state change occurs.
REQ-020 SHALL, on accept, go next cycle to ON if cmd_on>0, else to OFF if cmd_off>0, else to DONE.
REQ-021 SHALL drive led=mask in ON and led=0 in all other states, registered with the state, so led changes in the same cycle the state is entered.
REQ-022 SHALL leave ON on the cmd_on-th tick and leave OFF on the cmd_off-th tick, each counted from phase entry with a 16-bit phase counter cleared on entry.
REQ-023 SHALL end a repetition at the end of OFF, or at the end of ON when cmd_off==0.
REQ-024 SHALL decrement the 8-bit repetition counter at the end of each repetition; at 0 it goes to DONE, otherwise to ON, or to OFF when cmd_on==0.
REQ-025 SHALL hold led=mask with no gap across repetitions when cmd_off==0.
REQ-026 SHALL stay in DONE exactly one cycle with done=1, then return to IDLE.
REQ-027 SHALL, when abort is high in ON or OFF, go to DONE next cycle; abort has priority over phase transitions.
REQ-028 SHALL ignore abort in IDLE and DONE, apart from masking cmd_ready.

Reset
REQ-029 SHALL, with sys_rst high at a clock edge, force state=IDLE, led=0, busy=0, done=0, prescaler=0, phase and repetition counters=0, and all latched fields=0.
REQ-030 SHALL apply reset mid-operation with no done pulse; sys_rst has priority over every other input.
REQ-031 SHALL hold cmd_ready=0 while sys_rst is high and drive it per REQ-017 from the first cycle after release.

Configuration
REQ-032 SHALL use macro LED_BLINK_INFINITE_EN.
REQ-033 SHALL, with the macro defined, treat cmd_rep==0 as repeat-until-abort; the repetition counter is not decremented and done occurs only via abort.
REQ-034 SHALL, with the macro undefined, send a cmd_rep==0 command from accept straight to DONE; led stays 0 and done pulses at accept+1.

Verification
REQ-035 Scenario "reset": pulse sys_rst, cmd_valid=0 -> led=0, busy=0, done=0, cmd_ready=1 at the first cycle after release.
REQ-036 Scenario "two repetitions": TICK_DIV=4, mask=0101, on=2, off=1, rep=2, accept at cycle N -> led=0101 on N+1..N+8, 0 on N+9..N+12, 0101 on N+13..N+20, 0 on N+21..N+24; done=1 only at N+25; cmd_ready=1 at N+26.
REQ-037 Scenario "abort and busy": same command, abort at N+5 -> led=0 and done=1 at N+6, IDLE at N+7; a second cmd_valid at N+3 is not accepted.
REQ-038 Scenario "degenerate lengths": on=0, off=0 -> done at N+1, led never nonzero; on=3, off=0, rep=2 -> led=mask continuously on N+1..N+24, done at N+25.
REQ-039 Scenario "cmd_rep==0": macro defined -> blinking continues past 1000 ticks until abort; macro undefined -> done at N+1.
REQ-040 Scenario "reset mid-ON": sys_rst at N+4 -> at N+5 all outputs hold their reset values, done stays 0 throughout.
